seven_segment_reader: RTL and testbench
=======================================

Name: seven_segment_reader

Overview:
- Monitors a multiplexed, active-low seven-segment display bus (segments plus digit anodes) and recovers the displayed hex digits.
- Debounces each digit over consecutive scan samples, then decodes the stable pattern back to a nibble, or flags it as blank or illegal.
- Sits beside display drivers as a self-check and readback block, feeding status registers and the scoreboard.

Parameters:
- DIGITS, 4, number of multiplexed digits; sets anode and value widths; legal range 1..8.
- STABLE_CNT, 3, consecutive identical samples of a digit required before decode; must be ≥1.
- CNT_W, $clog2(STABLE_CNT+1), width of each per-digit stability counter; derived, do not override.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  one-cycle sample strobe from the scan timebase.
- an_n  input  DIGITS  digit enables, active-low; bit d selects digit d.
- seg_n  input  7  segment lines, active-low; bit0=a … bit6=g.
- value  output  4*DIGITS  decoded nibbles; digit d occupies [4d+3:4d].
- digit_valid  output  DIGITS  digit d currently shows a legal hex glyph.
- bad_pattern  output  DIGITS  digit d's last stable pattern is neither a hex glyph nor blank.
- update  output  1  one-cycle pulse: a digit's decoded state was just refreshed.
- upd_digit  output  $clog2(DIGITS) (min 1)  index of the refreshed digit; valid only with update.
- scan_err  output  1  one-cycle pulse: a sample had zero or more than one anode active.

Behaviour:
- Reset (async assert, sync-safe release):
  - value=0, digit_valid=0, bad_pattern=0, update=0, upd_digit=0, scan_err=0.
  - Per-digit last_seen=7'h7F, per-digit cnt=0.
- Inputs are sampled only on cycles with sample_en=1; all other cycles leave state unchanged except pulse outputs, which return to 0.
- Anode qualification:
  - ~an_n must be one-hot.
  - Otherwise: scan_err=1 next cycle, no digit state changes, update=0.
- For a qualified sample on digit d with pattern p:
  - If p==last_seen[d]: cnt[d]=min(cnt[d]+1, STABLE_CNT).
  - Else: last_seen[d]=p, cnt[d]=1.
  - Fire when new cnt[d]==STABLE_CNT and either (old cnt[d]<STABLE_CNT) or (p!=old last_seen[d]).
  - A held pattern therefore fires exactly once; a changed pattern re-fires after it restabilises. With STABLE_CNT=1, every changed sample fires.
- On fire (registered; outputs change the cycle after the sample edge; latency 1 clk):
  - update=1, upd_digit=d.
  - If p is a hex glyph: value[d]=nibble, digit_valid[d]=1, bad_pattern[d]=0.
  - If p==7'h7F (blank): digit_valid[d]=0, bad_pattern[d]=0, value[d] held.
  - Otherwise: digit_valid[d]=0, bad_pattern[d]=1, value[d] held.
- Decode table, seg_n {g..a} -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F. The table is exact-match only.
- Per-digit state is independent. Samples of other digits never reset cnt[d].
- Counters saturate at STABLE_CNT; there is no wrap-around.
- Reset asserted mid-debounce discards all partial counts. After release, a digit needs STABLE_CNT fresh samples to fire.
- Only one digit can be sampled per cycle, so update is never ambiguous.

Test Plan:
- Reset, then 3 samples an_n=4'b1110, seg_n=7'h24 -> update pulses once, 1 clk after the 3rd sample; upd_digit=0, value[3:0]=2, digit_valid=4'b0001; a 4th identical sample gives no update.
- Scan digits 0..3 round-robin, 3 passes, with patterns 0E, 00, 79, 46 -> value=16'hC18F, digit_valid=4'hF, exactly 4 update pulses.
- Digit 1 shows 19,19,30,30,30 -> no fire on the 19s; fires after the third 30 with value[7:4]=3; intermediate value[7:4] stays at its prior value.
- Digit 2 stable at 7'h55 -> bad_pattern[2]=1, digit_valid[2]=0, value[11:8] unchanged; then stable at 7'h7F -> bad_pattern[2]=0, digit_valid[2]=0.
- sample_en with an_n=4'b1100, then 4'b1111 -> scan_err pulses on each, no update, all counters unchanged (confirmed by 3 further good samples firing exactly on the 3rd).
- 2 good samples of digit 0, assert rst_n=0 mid-cycle, release -> outputs cleared immediately; 2 more samples produce no update; the 3rd fires.

Source files
------------

// File: rtl/seven_segment_reader.sv
// seven_segment_reader
// Watches a multiplexed, active-low seven-segment bus and recovers the hex
// digits it shows. Each digit is debounced over consecutive scan samples and
// then decoded to a nibble, or flagged as blank or as an illegal glyph.

module seven_segment_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     bad_pattern,
  output logic                  update,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] upd_digit,
  output logic                  scan_err
);

  localparam int               IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [6:0]       BLANK   = 7'h7F;

  // Per-digit debounce state: last pattern seen and how many times in a row.
  logic [6:0]       last_seen [DIGITS];
  logic [CNT_W-1:0] cnt       [DIGITS];

  // Decode of the current sample, for whichever digit is being driven.
  logic [DIGITS-1:0] sel;
  logic              one_hot;
  logic [IDX_W-1:0]  idx;
  logic              same;
  logic [CNT_W-1:0]  old_cnt;
  logic [CNT_W-1:0]  new_cnt;
  logic              fire;
  logic [4:0]        dec;

  // Exact-match glyph decode; bit 4 marks a legal hex glyph, bits 3:0 the nibble.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'b0_0000;
    endcase
  endfunction

  // Qualify the anodes, pick the active digit and compute its next debounce state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    sel     = ~an_n;
    one_hot = $onehot(sel);
    idx     = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (sel[d]) idx = IDX_W'(d);
    end
    old_cnt = cnt[idx];
    same    = (seg_n == last_seen[idx]);
    if (!same)                  new_cnt = CNT_ONE;
    else if (old_cnt == CNT_MAX) new_cnt = old_cnt;
    else                        new_cnt = old_cnt + CNT_ONE;
    // A held pattern fires once on reaching the threshold; a changed pattern
    // can only fire immediately when the threshold is a single sample.
    fire = (new_cnt == CNT_MAX) && ((old_cnt < CNT_MAX) || !same);
    dec  = decode(seg_n);
  end

  // Debounce state, decoded outputs and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      bad_pattern <= '0;
      update      <= 1'b0;
      upd_digit   <= '0;
      scan_err    <= 1'b0;
      // NOTE: the debounce arrays are reset on purpose: a digit must see a
      // full run of fresh samples after reset, so stale counts cannot linger.
      for (int d = 0; d < DIGITS; d++) begin
        last_seen[d] <= BLANK;
        cnt[d]       <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge values computed above regardless of statement order.
      update   <= 1'b0;
      scan_err <= 1'b0;
      if (sample_en) begin
        if (!one_hot) begin
          scan_err <= 1'b1;
        end else begin
          last_seen[idx] <= seg_n;
          cnt[idx]       <= new_cnt;
          if (fire) begin
            update    <= 1'b1;
            upd_digit <= idx;
            if (dec[4]) begin
              value[4*idx +: 4] <= dec[3:0];
              digit_valid[idx]  <= 1'b1;
              bad_pattern[idx]  <= 1'b0;
            end else if (seg_n == BLANK) begin
              digit_valid[idx]  <= 1'b0;
              bad_pattern[idx]  <= 1'b0;
            end else begin
              digit_valid[idx]  <= 1'b0;
              bad_pattern[idx]  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed testbench for seven_segment_reader (DIGITS=4, STABLE_CNT=3).
// Each sample is one sample_en cycle followed by an idle cycle; outputs are
// read on the falling edge after the sampling edge.

module tb_seven_segment_reader;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  bad_pattern;
  logic        update;
  logic [1:0]  upd_digit;
  logic        scan_err;

  int n_cmp = 0;
  int n_bad = 0;

  seven_segment_reader #(.DIGITS(4), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .value       (value),
    .digit_valid (digit_valid),
    .bad_pattern (bad_pattern),
    .update      (update),
    .upd_digit   (upd_digit),
    .scan_err    (scan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sample cycle; returns the pulse outputs seen the cycle after.
  task automatic sample(input logic [3:0] an, input logic [6:0] seg,
                        output logic upd, output logic [1:0] ud, output logic serr);
    @(negedge clk);
    sample_en = 1'b1;
    an_n      = an;
    seg_n     = seg;
    @(negedge clk);
    sample_en = 1'b0;
    an_n      = 4'hF;
    seg_n     = 7'h7F;
    upd       = update;
    ud        = upd_digit;
    serr      = scan_err;
  endtask

  task automatic apply_reset();
    sample_en = 1'b0;
    an_n      = 4'hF;
    seg_n     = 7'h7F;
    #2 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({value, digit_valid, bad_pattern, update, upd_digit, scan_err} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: value=%h valid=%b bad=%b upd=%b ud=%0d serr=%b, required all zero",
               value, digit_valid, bad_pattern, update, upd_digit, scan_err);
    end
  endtask

  task automatic test_basic();
    logic u, s;
    logic [1:0] ud;
    for (int i = 0; i < 2; i++) begin
      sample(4'b1110, 7'h24, u, ud, s);
      n_cmp++;
      if (u !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_early_update: sample %0d update=%b, required 0", i, u);
      end
    end
    sample(4'b1110, 7'h24, u, ud, s);
    n_cmp++;
    if ({u, ud, value[3:0], digit_valid} !== {1'b1, 2'd0, 4'h2, 4'b0001}) begin
      n_bad++;
      $display("FAIL basic_fire: update=%b ud=%0d value=%h valid=%b, required 1 0 2 0001",
               u, ud, value[3:0], digit_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (update !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse_width: update=%b one cycle later, required 0", update);
    end
    sample(4'b1110, 7'h24, u, ud, s);
    n_cmp++;
    if (u !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_held_refire: update=%b on 4th sample, required 0", u);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] an_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab [4] = '{7'h0E, 7'h00, 7'h79, 7'h46};
    logic u, s;
    logic [1:0] ud;
    int fires;
    apply_reset();
    fires = 0;
    for (int p = 0; p < 3; p++) begin
      for (int d = 0; d < 4; d++) begin
        sample(an_tab[d], seg_tab[d], u, ud, s);
        if (u === 1'b1) begin
          fires++;
          n_cmp++;
          if (p != 2 || ud !== 2'(d)) begin
            n_bad++;
            $display("FAIL rr_fire_position: fire in pass %0d ud=%0d, required pass 2 ud=%0d", p, ud, d);
          end
        end
      end
    end
    n_cmp++;
    if (fires != 4) begin
      n_bad++;
      $display("FAIL rr_update_count: %0d updates, required 4", fires);
    end
    n_cmp++;
    if ({value, digit_valid} !== {16'hC18F, 4'hF}) begin
      n_bad++;
      $display("FAIL rr_values: value=%h valid=%h, required C18F F", value, digit_valid);
    end
  endtask

  task automatic test_change();
    logic [6:0] seq [5] = '{7'h19, 7'h19, 7'h30, 7'h30, 7'h30};
    logic u, s;
    logic [1:0] ud;
    for (int i = 0; i < 5; i++) begin
      sample(4'b1101, seq[i], u, ud, s);
      n_cmp++;
      if (i < 4) begin
        if ({u, value[7:4]} !== {1'b0, 4'h8}) begin
          n_bad++;
          $display("FAIL change_hold: sample %0d update=%b value=%h, required 0 8", i, u, value[7:4]);
        end
      end else if ({u, ud, value[7:4], digit_valid[1]} !== {1'b1, 2'd1, 4'h3, 1'b1}) begin
        n_bad++;
        $display("FAIL change_fire: update=%b ud=%0d value=%h valid=%b, required 1 1 3 1",
                 u, ud, value[7:4], digit_valid[1]);
      end
    end
  endtask

  task automatic test_bad_and_blank();
    logic u, s;
    logic [1:0] ud;
    repeat (3) sample(4'b1011, 7'h55, u, ud, s);
    n_cmp++;
    if ({u, bad_pattern[2], digit_valid[2], value[11:8]} !== {1'b1, 1'b1, 1'b0, 4'h1}) begin
      n_bad++;
      $display("FAIL bad_glyph: update=%b bad=%b valid=%b value=%h, required 1 1 0 1",
               u, bad_pattern[2], digit_valid[2], value[11:8]);
    end
    repeat (3) sample(4'b1011, 7'h7F, u, ud, s);
    n_cmp++;
    if ({u, bad_pattern[2], digit_valid[2], value[11:8]} !== {1'b1, 1'b0, 1'b0, 4'h1}) begin
      n_bad++;
      $display("FAIL blank_glyph: update=%b bad=%b valid=%b value=%h, required 1 0 0 1",
               u, bad_pattern[2], digit_valid[2], value[11:8]);
    end
  endtask

  task automatic test_scan_err();
    logic u, s;
    logic [1:0] ud;
    logic [3:0] err_tab [2] = '{4'b1100, 4'b1111};
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      sample(err_tab[i], 7'h08, u, ud, s);
      n_cmp++;
      if ({s, u} !== 2'b10) begin
        n_bad++;
        $display("FAIL scan_err_pulse: an_n=%b scan_err=%b update=%b, required 1 0", err_tab[i], s, u);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (scan_err !== 1'b0) begin
      n_bad++;
      $display("FAIL scan_err_width: scan_err=%b one cycle later, required 0", scan_err);
    end
    for (int i = 0; i < 3; i++) begin
      sample(4'b1110, 7'h08, u, ud, s);
      n_cmp++;
      if (u !== (i == 2)) begin
        n_bad++;
        $display("FAIL scan_err_counters: good sample %0d update=%b, required %0d", i, u, (i == 2));
      end
    end
    n_cmp++;
    if ({value[3:0], digit_valid} !== {4'hA, 4'b0001}) begin
      n_bad++;
      $display("FAIL scan_err_decode: value=%h valid=%b, required A 0001", value[3:0], digit_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic u, s;
    logic [1:0] ud;
    repeat (2) sample(4'b1110, 7'h10, u, ud, s);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({value, digit_valid} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: value=%h valid=%b, required 0 0", value, digit_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(4'b1110, 7'h10, u, ud, s);
      n_cmp++;
      if (u !== (i == 2)) begin
        n_bad++;
        $display("FAIL reset_mid_refire: sample %0d update=%b, required %0d", i, u, (i == 2));
      end
    end
    n_cmp++;
    if ({value[3:0], digit_valid[0]} !== {4'h9, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_value: value=%h valid=%b, required 9 1", value[3:0], digit_valid[0]);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    sample_en = 1'b0;
    an_n      = 4'hF;
    seg_n     = 7'h7F;
    test_reset();
    test_basic();
    test_round_robin();
    test_change();
    test_bad_and_blank();
    test_scan_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
